// File: rtl/axil_regbank_slave.sv
// AXI4-Lite register bank: NUM_RW byte-strobed control registers and NUM_RO status words,
// with per-register write pulses and per-status-word read pulses for user logic.
module axil_regbank_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 28,
    parameter int NUM_RW             = 8,
    parameter int NUM_RO             = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [NUM_RW-1:0]                      wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0] rd_pulse
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDXW     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int NRO      = (NUM_RO > 0) ? NUM_RO : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic            aw_full_q, w_full_q;
    logic [IDXW-1:0] aw_idx_q;
    logic [DW-1:0]   w_data_q;
    logic [SW-1:0]   w_strb_q;
    logic            bvalid_q, rvalid_q;
    logic [1:0]      bresp_q, rresp_q;
    logic [DW-1:0]   rdata_q;
    logic [NUM_RW-1:0] wr_pulse_q;
    logic [NRO-1:0]  rd_pulse_q;
    logic [DW-1:0]   regs_q [NUM_RW];

    logic            aw_hs, w_hs, ar_hs, wr_commit;
    logic [IDXW-1:0] ar_idx;
    logic [NUM_RW-1:0] wr_rw_hit, rd_rw_hit;
    logic [NRO-1:0]  rd_ro_hit;
    logic [DW-1:0]   rd_word;

    // Ready outputs are gated by reset so they read low while reset is asserted.
    assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full_q;
    assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_full_q;
    assign S_AXI_ARREADY = S_AXI_ARESETN & ~rvalid_q;

    assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign wr_commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);
    assign ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        wr_rw_hit = '0;
        rd_rw_hit = '0;
        rd_ro_hit = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            wr_rw_hit[i] = (aw_idx_q == IDXW'(i));
            rd_rw_hit[i] = (ar_idx == IDXW'(i));
        end
        for (int j = 0; j < NUM_RO; j++) begin
            rd_ro_hit[j] = (ar_idx == IDXW'(NUM_RW + j));
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_rw_hit[i]) rd_word = regs_q[i];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rd_ro_hit[j]) rd_word = status_in[j*DW +: DW];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end else if (wr_commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end else if (wr_commit) begin
                w_full_q <= 1'b0;
            end
            if (wr_commit) begin
                bvalid_q   <= 1'b1;
                bresp_q    <= (|wr_rw_hit) ? RESP_OKAY : RESP_SLVERR;
                wr_pulse_q <= (|w_strb_q) ? wr_rw_hit : '0;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
                for (int b = 0; b < SW; b++) begin
                    if (wr_rw_hit[i] && w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                end
            end
        end
    end

    // RDATA/RRESP only load on an AR handshake, which cannot happen while RVALID is held.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            if (ar_hs) begin
                rvalid_q   <= 1'b1;
                rdata_q    <= rd_word;
                rresp_q    <= (|rd_rw_hit || |rd_ro_hit) ? RESP_OKAY : RESP_SLVERR;
                rd_pulse_q <= rd_ro_hit;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
        assign reg_out[g*DW +: DW] = regs_q[g];
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign wr_pulse     = wr_pulse_q;
    assign rd_pulse     = rd_pulse_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_axil_regbank_slave.sv
// Directed bench for axil_regbank_slave with the default 32-bit, 8 RW / 4 RO configuration.
module tb_axil_regbank_slave;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [27:0]  awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic [127:0] status_in;
    logic [3:0]   rd_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int bv_seen;

    always #5 clk = ~clk;

    axil_regbank_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in), .rd_pulse(rd_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        status_in = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hA5A5A5A5};
        tick(); tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_reg_out", reg_out[63:0], 0);
        rst_n = 1'b1;
        #1;
        check("rel_awready", awready, 1);
        check("rel_arready", arready, 1);
        check("rel_rdata", rdata, 0);

        // Write 0x004 with AW and W together
        tick();
        awaddr = 28'h004; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_awready_held", awready, 0);
        check("t1_bvalid_early", bvalid, 0);
        tick();
        check("t1_bvalid", bvalid, 1);
        check("t1_bresp", bresp, 2'b00);
        check("t1_reg1", reg_out[63:32], 32'hDEADBEEF);
        check("t1_wr_pulse", wr_pulse, 8'h02);
        tick();
        check("t1_bvalid_clr", bvalid, 0);
        check("t1_wr_pulse_clr", wr_pulse, 8'h00);

        // W leads AW by three cycles, partial strobe
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_wready_low0", wready, 0);
        tick();
        check("t2_wready_low1", wready, 0);
        check("t2_no_bvalid", bvalid, 0);
        tick();
        awaddr = 28'h004; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t2_wready_low2", wready, 0);
        tick();
        check("t2_bvalid", bvalid, 1);
        check("t2_reg1", reg_out[63:32], 32'hDE22BE44);
        check("t2_wready_back", wready, 1);
        tick();

        // RO read with clear-on-read pulse
        araddr = 28'h020; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t3_rvalid", rvalid, 1);
        check("t3_rdata", rdata, 32'hA5A5A5A5);
        check("t3_rresp", rresp, 2'b00);
        check("t3_rd_pulse", rd_pulse, 4'h1);
        check("t3_arready_low", arready, 0);
        tick();
        check("t3_rvalid_clr", rvalid, 0);
        check("t3_rd_pulse_clr", rd_pulse, 4'h0);
        araddr = 28'h007; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t3_rw_read", rdata, 32'hDE22BE44);
        tick();

        // Write to RO word and read illegal address concurrently
        awaddr = 28'h020; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 28'h040; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("t4_rvalid", rvalid, 1);
        check("t4_rresp", rresp, 2'b10);
        check("t4_rdata", rdata, 0);
        tick();
        check("t4_bvalid", bvalid, 1);
        check("t4_bresp", bresp, 2'b10);
        check("t4_wr_pulse", wr_pulse, 0);
        check("t4_regs_lo", reg_out[127:0], {64'h0, 32'hDE22BE44, 32'h0});
        check("t4_regs_hi", reg_out[255:128], 0);
        tick();

        // All-zero strobe
        awaddr = 28'h008; awvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'h0; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t5_bresp_okay", bresp, 2'b00);
        check("t5_bvalid", bvalid, 1);
        check("t5_wr_pulse", wr_pulse, 0);
        check("t5_reg2", reg_out[95:64], 0);
        tick();

        // Read and write commit to the same register at the same edge
        awaddr = 28'h000; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 28'h000; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t6_read_old", rdata, 0);
        check("t6_reg0_new", reg_out[31:0], 32'h12345678);
        check("t6_wr_pulse", wr_pulse, 8'h01);
        tick();

        // Backpressure on B and R
        bready = 1'b0; rready = 1'b0;
        awaddr = 28'h00C; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 28'h004; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        awaddr = 28'h010; awvalid = 1'b1; wdata = 32'h0BADC0DE; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t7_bvalid_hold", bvalid, 1);
            check("t7_bresp_hold", bresp, 2'b00);
            check("t7_rvalid_hold", rvalid, 1);
            check("t7_rdata_hold", rdata, 32'hDE22BE44);
            check("t7_rresp_hold", rresp, 2'b00);
            check("t7_awready_low", awready, 0);
            check("t7_wready_low", wready, 0);
            check("t7_arready_low", arready, 0);
            tick();
        end
        check("t7_reg3", reg_out[127:96], 32'hCAFEF00D);
        check("t7_reg4_pending", reg_out[159:128], 0);
        bready = 1'b1; rready = 1'b1;
        tick();
        check("t7_second_bvalid", bvalid, 1);
        check("t7_reg4", reg_out[159:128], 32'h0BADC0DE);
        check("t7_rvalid_clr", rvalid, 0);
        tick();
        check("t7_bvalid_clr", bvalid, 0);

        // Reset with AW held and W never delivered
        awaddr = 28'h000; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t8_awready_in_rst", awready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t8_awready_rel", awready, 1);
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        bv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bvalid) bv_seen++;
            tick();
        end
        check("t8_no_bvalid", bv_seen, 0);
        check("t8_reg_out_zero", reg_out == '0, 1);
        for (int i = 0; i < 8; i++) begin
            araddr = 28'(i * 4); arvalid = 1'b1;
            tick();
            arvalid = 1'b0;
            check("t8_read_zero", rdata, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_regbank_slave.md
Name: axil_regbank_slave

Overview:
- Parametrised AXI4-Lite slave register bank; the next generation of the team's fixed two-register AXI-Lite peripheral.
- Provides NUM_RW read/write control registers with WSTRB byte enables and NUM_RO read-only status words.
- Accepts AW and W independently, returns SLVERR for illegal accesses, registers read data, and emits per-register write and read pulses to user logic.
- Sits between the core's AXI-Lite interconnect and a peripheral datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
C_S_AXI_ADDR_WIDTH, 28, byte address width.
NUM_RW, 8, number of RW registers; 1..64.
NUM_RO, 4, number of RO status words; 0..64.

Ports:
S_AXI_ACLK  in  1  clock; all logic is on the rising edge.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
S_AXI_BRESP  out  2  write response; 00 = OKAY, 10 = SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
reg_out  out  NUM_RW*C_S_AXI_DATA_WIDTH  flattened RW register contents; register i occupies slice i.
wr_pulse  out  NUM_RW  one-cycle pulse per RW register written.
status_in  in  max(NUM_RO,1)*C_S_AXI_DATA_WIDTH  RO status words.
rd_pulse  out  max(NUM_RO,1)  one-cycle pulse per RO word read, for clear-on-read use.

Behaviour:
- Reset (asynchronous, S_AXI_ARESETN low):
  - Clears all RW registers, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse, rd_pulse and both holding flags.
  - An in-flight transaction is dropped with no response.
  - AWREADY, WREADY and ARREADY are 0 during reset and 1 in the first cycle after release.
- Decode:
  - Word index = addr >> log2(C_S_AXI_DATA_WIDTH/8); low byte-offset bits are ignored.
  - idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO word.
  - Otherwise: illegal.
- Write path:
  - AWREADY = ~aw_full; WREADY = ~w_full.
  - Each handshake latches its address, or data plus strobe, into a one-entry holding register and sets the matching flag.
  - Channels are independent: AW and W may arrive in either order, any number of cycles apart.
  - Commit condition: aw_full & w_full & (~BVALID | BREADY).
  - At the commit edge:
    - For an RW target, bytes whose strobe bit is 1 are updated.
    - Both flags clear; BVALID is set.
    - BRESP = OKAY for an RW target, SLVERR for an RO or illegal target; SLVERR writes have no effect.
    - wr_pulse[idx] is high for exactly the cycle after the commit, only if the target is RW and WSTRB != 0.
  - An all-zero WSTRB returns OKAY and changes nothing.
  - Minimum latency: AW and W handshakes together at edge n give BVALID high after edge n+1.
  - BVALID and BRESP hold until BREADY. Throughput is one write per 2 cycles.
- Read path:
  - ARREADY = ~RVALID.
  - An AR handshake at edge n registers RDATA/RRESP and sets RVALID after edge n.
  - RW target: RDATA = register value, RRESP = OKAY.
  - RO target: RDATA = status_in sampled at edge n, RRESP = OKAY; rd_pulse[idx-NUM_RW] is high for the following cycle.
  - Illegal target: RDATA = 0, RRESP = SLVERR.
  - RDATA, RRESP and RVALID hold stable until RREADY; RVALID clears on that edge.
- Simultaneous read and write commit to the same register at the same edge: the read returns the old value.
- Read and write paths operate concurrently with no mutual stall.
- reg_out is driven directly from the register flops, with no added latency.

Test Plan:
- Reset, then AW 0x004 and W 0xDEADBEEF with WSTRB=F in the same cycle, BREADY=1 -> BVALID two cycles later with BRESP=00; reg_out[1]=0xDEADBEEF; wr_pulse=0x02 for one cycle.
- W 0x11223344 with WSTRB=0x5 to address 0x004 three cycles before its AW -> WREADY low until commit; reg_out[1]=0xDE22BE44.
- Read 0x020 (RO word 0) with status_in word 0 = 0xA5A5A5A5 -> RVALID one cycle after the handshake; RDATA=0xA5A5A5A5; RRESP=00; rd_pulse[0] high for 1 cycle.
- Write to 0x020 and read from 0x040 -> BRESP=10 with no register change; RRESP=10 with RDATA=0.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stable throughout; AWREADY/WREADY drop after the next held handshake; ARREADY stays low while RVALID is high.
- Assert reset for 1 cycle while AW is held but W is pending -> no BVALID ever appears; all registers read 0 afterwards.
